// File: rtl/store_buffer_fwd.sv
// Store buffer between the LSU/MMU and the dcache.
// A BLEN-deep FIFO of stores retired to the dcache in program order over a
// req/ack handshake, with per-byte store-to-load forwarding in which the
// youngest matching store wins, plus an occupancy count.
module store_buffer_fwd #(
    parameter int BLEN           = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Enqueue side (LSU)
    input  logic                      lsu2stb_req,
    input  logic [ADDR_WIDTH-1:0]     lsu2stb_addr,
    input  logic [DATA_WIDTH-1:0]     lsu2stb_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] lsu2stb_sel_byte,
    output logic                      stb2lsu_ack,
    // Retire side (dcache)
    output logic                      stb2dcache_req,
    output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      dcache2stb_ack,
    // Forwarding lookup
    input  logic [ADDR_WIDTH-1:0]     lsu2stb_ld_addr,
    output logic                      stb2lsu_fwd_hit,
    output logic [DATA_WIDTH-1:0]     stb2lsu_fwd_data,
    output logic [BYTE_SEL_WIDTH-1:0] stb2lsu_fwd_sel_byte,
    // Status
    output logic                      stb_full,
    output logic                      stb_empty,
    output logic [$clog2(BLEN):0]     stb_count
);

    localparam int PTR_W = $clog2(BLEN);
    localparam int CNT_W = PTR_W + 1;
    // Low address bits that select a byte within a data word.
    localparam int OFF_W = $clog2(BYTE_SEL_WIDTH);

    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [BLEN-1:0]           valid_q;

    logic [ADDR_WIDTH-1:0]     addr_q [BLEN];
    logic [DATA_WIDTH-1:0]     data_q [BLEN];
    logic [BYTE_SEL_WIDTH-1:0] sel_q  [BLEN];

    logic enq;
    logic deq;

    assign stb_full    = (count_q == CNT_W'(BLEN));
    assign stb_empty   = (count_q == '0);
    assign stb_count   = count_q;
    assign stb2lsu_ack = !stb_full;

    // A full buffer never accepts, even when the head retires in the same cycle.
    assign enq = lsu2stb_req && !stb_full;
    assign deq = !stb_empty && dcache2stb_ack;

    // Head entry is presented straight from rd_ptr; zeroed while empty.
    assign stb2dcache_req      = !stb_empty;
    assign stb2dcache_addr     = stb_empty ? '0 : addr_q[rd_ptr_q];
    assign stb2dcache_wdata    = stb_empty ? '0 : data_q[rd_ptr_q];
    assign stb2dcache_sel_byte = stb_empty ? '0 : sel_q[rd_ptr_q];

    // Pointers, occupancy and valid bits; reset discards every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values; blocking would make the order of statements matter.
            if (enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload write on enqueue.
    // NOTE: the payload arrays carry no reset; the valid bits and count already
    // gate every read, and leaving them unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= lsu2stb_addr;
            data_q[wr_ptr_q] <= lsu2stb_wdata;
            sel_q[wr_ptr_q]  <= lsu2stb_sel_byte;
        end
    end

    // Forwarding: walk entries oldest to youngest from rd_ptr so that a younger
    // match overwrites an older one byte by byte.
    logic [PTR_W-1:0] fwd_idx;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value held, which would infer a latch.
        stb2lsu_fwd_data     = '0;
        stb2lsu_fwd_sel_byte = '0;
        fwd_idx              = '0;
        for (int a = 0; a < BLEN; a++) begin
            fwd_idx = rd_ptr_q + PTR_W'(a);
            if (valid_q[fwd_idx] &&
                addr_q[fwd_idx][ADDR_WIDTH-1:OFF_W] == lsu2stb_ld_addr[ADDR_WIDTH-1:OFF_W]) begin
                for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
                    if (sel_q[fwd_idx][b]) begin
                        stb2lsu_fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                        stb2lsu_fwd_sel_byte[b]    = 1'b1;
                    end
                end
            end
        end
    end

    assign stb2lsu_fwd_hit = |stb2lsu_fwd_sel_byte;

    // The byte-offset bits of the load address play no part in the match.
    generate
        if (OFF_W > 0) begin : g_ld_off
            logic ld_off_unused;
            assign ld_off_unused = ^lsu2stb_ld_addr[OFF_W-1:0];
        end
    endgenerate

endmodule
